// File: rtl/hdmi_out_fetch_ctrl.sv
// Write-side fetch sequencer for the HDMI output FIFO: walks the active frame
// line by line, issues space-gated burst reads and pushes returned beats.
module hdmi_out_fetch_ctrl #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_AW      = 28,
  parameter int BURST_LEN   = 64,
  parameter int H_WORDS     = 480,
  parameter int V_LINES     = 1080,
  parameter int FB_BASE     = 0,
  parameter int LINE_STRIDE = 512,
  parameter int MARGIN      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_start,
  input  logic [ADDR_WIDTH:0]   fifo_wr_water_level,
  input  logic                  fifo_full,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_wr_data,
  output logic                  rd_req,
  output logic [MEM_AW-1:0]     rd_addr,
  output logic [8:0]            rd_len,
  input  logic                  rd_req_ack,
  input  logic                  rd_data_valid,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overflow_err
);

  localparam int WW = $clog2(H_WORDS + 1);
  localparam int LW = $clog2(V_LINES + 1);
  localparam int FW = ADDR_WIDTH + 2;

  localparam logic [FW-1:0]     DEPTH_F   = FW'(64'd1 << ADDR_WIDTH);
  localparam logic [MEM_AW-1:0] BASE_A    = MEM_AW'(FB_BASE);
  localparam logic [MEM_AW-1:0] STRIDE_A  = MEM_AW'(LINE_STRIDE);
  localparam logic [WW-1:0]     H_W       = WW'(H_WORDS);
  localparam logic [LW-1:0]     V_L       = LW'(V_LINES);
  localparam logic [8:0]        BURST_L   = 9'(BURST_LEN);
  localparam logic [31:0]       BURST_32  = 32'(BURST_LEN);
  localparam logic [31:0]       MARGIN_32 = 32'(MARGIN);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_REQ   = 2'd2,
    ST_DATA  = 2'd3
  } state_t;

  state_t            state_r;
  logic [WW-1:0]     word_r;
  logic [LW-1:0]     line_r;
  logic [MEM_AW-1:0] line_addr_r;
  logic [8:0]        beat_r;
  logic              drop_r;

  logic [FW-1:0]     used_s;
  logic [FW-1:0]     free_s;
  logic [31:0]       rem_s;
  logic [31:0]       need_s;
  logic [8:0]        len_s;
  logic              room_s;
  logic [WW-1:0]     word_sum_s;
  logic [LW-1:0]     line_inc_s;
  logic              last_beat_s;
  logic              drop_s;
  logic              wr_s;

  // Free space, next burst length and burst bookkeeping terms
  always_comb begin
    used_s = {1'b0, fifo_wr_water_level} + {{(FW-1){1'b0}}, fifo_wr_en};
    // a level beyond depth (pending write included) means no room at all
    if (used_s > DEPTH_F) begin
      free_s = {FW{1'b0}};
    end else begin
      free_s = DEPTH_F - used_s;
    end
    rem_s = 32'(H_W - word_r);
    if (rem_s > BURST_32) begin
      len_s = BURST_L;
    end else begin
      len_s = rem_s[8:0];
    end
    need_s      = 32'(len_s) + MARGIN_32;
    room_s      = (32'(free_s) >= need_s);
    word_sum_s  = word_r + WW'(rd_len);
    line_inc_s  = line_r + LW'(1'b1);
    last_beat_s = (beat_r == (rd_len - 9'd1));
    drop_s      = drop_r | frame_start;
    wr_s        = rd_data_valid & (state_r == ST_DATA) & ~drop_s;
  end

  // Sequencer state machine with registered outputs and FIFO write stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      word_r       <= {WW{1'b0}};
      line_r       <= {LW{1'b0}};
      line_addr_r  <= BASE_A;
      beat_r       <= 9'd0;
      drop_r       <= 1'b0;
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= {DATA_WIDTH{1'b0}};
      rd_req       <= 1'b0;
      rd_addr      <= {MEM_AW{1'b0}};
      rd_len       <= 9'd0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      frame_done   <= 1'b0;
      fifo_wr_en   <= wr_s;
      fifo_wr_data <= rd_data;
      if (frame_start) begin
        overflow_err <= 1'b0;
      end else if (wr_s && fifo_full) begin
        overflow_err <= 1'b1;
      end

      case (state_r)
        ST_IDLE: begin
          if (frame_start) begin
            word_r      <= {WW{1'b0}};
            line_r      <= {LW{1'b0}};
            line_addr_r <= BASE_A;
            busy        <= 1'b1;
            state_r     <= ST_CHECK;
          end
        end

        ST_CHECK: begin
          if (frame_start) begin
            word_r      <= {WW{1'b0}};
            line_r      <= {LW{1'b0}};
            line_addr_r <= BASE_A;
          end else if (room_s) begin
            rd_addr <= line_addr_r + MEM_AW'(word_r);
            rd_len  <= len_s;
            rd_req  <= 1'b1;
            state_r <= ST_REQ;
          end
        end

        ST_REQ: begin
          // a restart cannot retract an issued request; its beats are dropped
          if (frame_start) begin
            drop_r <= 1'b1;
          end
          if (rd_req && rd_req_ack) begin
            rd_req  <= 1'b0;
            beat_r  <= 9'd0;
            state_r <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (rd_data_valid && last_beat_s) begin
            if (drop_s) begin
              drop_r      <= 1'b0;
              word_r      <= {WW{1'b0}};
              line_r      <= {LW{1'b0}};
              line_addr_r <= BASE_A;
              state_r     <= ST_CHECK;
            end else if (word_sum_s == H_W) begin
              word_r      <= {WW{1'b0}};
              line_r      <= line_inc_s;
              line_addr_r <= line_addr_r + STRIDE_A;
              if (line_inc_s == V_L) begin
                busy       <= 1'b0;
                frame_done <= 1'b1;
                state_r    <= ST_IDLE;
              end else begin
                state_r <= ST_CHECK;
              end
            end else begin
              word_r  <= word_sum_s;
              state_r <= ST_CHECK;
            end
          end else begin
            if (rd_data_valid) begin
              beat_r <= beat_r + 9'd1;
            end
            if (frame_start) begin
              drop_r <= 1'b1;
            end
          end
        end

        default: begin
          rd_req  <= 1'b0;
          drop_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hdmi_out_fetch_ctrl.sv
// Randomized bench for hdmi_out_fetch_ctrl: a frame-level burst/beat model
// plus a memory responder, all stepped from one process per clock.
module tb_hdmi_out_fetch_ctrl;

  localparam int ADDR_WIDTH  = 10;
  localparam int DATA_WIDTH  = 32;
  localparam int MEM_AW      = 28;
  localparam int BURST_LEN   = 64;
  localparam int H_WORDS     = 100;
  localparam int V_LINES     = 2;
  localparam int FB_BASE     = 0;
  localparam int LINE_STRIDE = 512;
  localparam int MARGIN      = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  frame_start;
  logic [ADDR_WIDTH:0]   fifo_wr_water_level;
  logic                  fifo_full;
  logic                  fifo_wr_en;
  logic [DATA_WIDTH-1:0] fifo_wr_data;
  logic                  rd_req;
  logic [MEM_AW-1:0]     rd_addr;
  logic [8:0]            rd_len;
  logic                  rd_req_ack;
  logic                  rd_data_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  busy;
  logic                  frame_done;
  logic                  overflow_err;

  always #5 clk = ~clk;

  hdmi_out_fetch_ctrl #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .MEM_AW(MEM_AW),
    .BURST_LEN(BURST_LEN), .H_WORDS(H_WORDS), .V_LINES(V_LINES),
    .FB_BASE(FB_BASE), .LINE_STRIDE(LINE_STRIDE), .MARGIN(MARGIN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .fifo_wr_water_level(fifo_wr_water_level), .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len),
    .rd_req_ack(rd_req_ack), .rd_data_valid(rd_data_valid), .rd_data(rd_data),
    .busy(busy), .frame_done(frame_done), .overflow_err(overflow_err)
  );

  typedef struct {
    logic [63:0] addr;
    int          len;
  } req_t;

  req_t                  exp_req[$];
  logic [DATA_WIDTH-1:0] exp_wr[$];

  int ncmp = 0;
  int nerr = 0;
  int nwr = 0;
  int ndone = 0;
  int req_cycles = 0;
  int beats_left = 0;
  int beats_done = 0;
  int beat_glob = 0;
  int wait_cnt = 0;
  int ack_delay = 0;
  int restart_at = -1;
  int full_at = -1;
  int frame_bursts = 0;
  bit start_req = 1'b0;
  bit tb_drop = 1'b0;
  bit stray_en = 1'b0;
  bit rand_in = 1'b0;
  bit rand_ack = 1'b0;
  logic [ADDR_WIDTH:0] level = '0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected burst list of one whole frame, straight from the line/burst rules
  task automatic build_frame();
    int   w;
    int   n;
    req_t r;
    exp_req.delete();
    for (int l = 0; l < V_LINES; l++) begin
      w = 0;
      while (w < H_WORDS) begin
        n = (H_WORDS - w < BURST_LEN) ? (H_WORDS - w) : BURST_LEN;
        r.addr = 64'((FB_BASE + l * LINE_STRIDE + w) % (1 << MEM_AW));
        r.len  = n;
        exp_req.push_back(r);
        w += n;
      end
    end
    frame_bursts = exp_req.size();
  endtask

  // One clock: observe outputs, then drive the memory side for the next edge
  task automatic tick();
    req_t r;
    @(posedge clk);
    #1;
    if (fifo_wr_en === 1'b1) begin
      if (exp_wr.size() == 0) begin
        check_eq("wr_unexpected", 64'(fifo_wr_en), 64'd0);
      end else begin
        check_eq("wr_data", 64'(fifo_wr_data), 64'(exp_wr.pop_front()));
        nwr++;
      end
    end
    if (frame_done === 1'b1) begin
      ndone++;
      check_eq("done_with_wr", 64'(fifo_wr_en), 64'd1);
      check_eq("done_busy", 64'(busy), 64'd0);
      check_eq("done_pending", 64'(exp_wr.size() + exp_req.size()), 64'd0);
    end
    if (rd_req === 1'b1) req_cycles++;

    rd_req_ack    = 1'b0;
    rd_data_valid = 1'b0;
    fifo_full     = 1'b0;
    frame_start   = 1'b0;
    if (rand_in) begin
      frame_start         = 1'($urandom_range(0, 1));
      rd_req_ack          = 1'($urandom_range(0, 1));
      rd_data_valid       = 1'($urandom_range(0, 1));
      fifo_full           = 1'($urandom_range(0, 1));
      rd_data             = $urandom;
      fifo_wr_water_level = (ADDR_WIDTH+1)'($urandom);
    end else begin
      fifo_wr_water_level = level;
      if (start_req) begin
        frame_start = 1'b1;
        start_req   = 1'b0;
        build_frame();
        if (beats_left > 0) tb_drop = 1'b1;
      end else if (beats_left > 0) begin
        if (rd_req === 1'b1) check_eq("req_in_burst", 64'(rd_req), 64'd0);
        if (beats_done == restart_at) begin
          frame_start = 1'b1;
          restart_at  = -1;
          tb_drop     = 1'b1;
          build_frame();
        end else if ($urandom_range(0, 3) != 0) begin
          rd_data_valid = 1'b1;
          rd_data       = $urandom;
          beats_left--;
          beats_done++;
          beat_glob++;
          if (!tb_drop) exp_wr.push_back(rd_data);
          if (beat_glob == full_at) fifo_full = 1'b1;
          if (beats_left == 0) tb_drop = 1'b0;
        end
      end else if (rd_req === 1'b1) begin
        if (exp_req.size() == 0) begin
          check_eq("req_unexpected", 64'(rd_req), 64'd0);
        end else begin
          check_eq("rd_addr", 64'(rd_addr), exp_req[0].addr);
          check_eq("rd_len", 64'(rd_len), 64'(exp_req[0].len));
          if (wait_cnt >= ack_delay) begin
            rd_req_ack = 1'b1;
            r          = exp_req.pop_front();
            beats_left = r.len;
            beats_done = 0;
            wait_cnt   = 0;
            if (rand_ack) ack_delay = $urandom_range(0, 4);
          end else begin
            wait_cnt++;
          end
        end
      end else begin
        wait_cnt = 0;
        // stray beats outside a burst must be ignored entirely
        if (stray_en && $urandom_range(0, 7) == 0) begin
          rd_data_valid = 1'b1;
          rd_data       = $urandom;
          fifo_full     = 1'($urandom_range(0, 1));
        end
      end
    end
  endtask

  task automatic wait_done(input int budget);
    int d0 = ndone;
    int c = 0;
    while (ndone == d0 && c < budget) begin
      tick();
      c++;
    end
    check_eq("frame_done_seen", 64'(ndone - d0), 64'd1);
  endtask

  task automatic run_frame(input int restart, input int full_off);
    int w0 = nwr;
    int d0;
    restart_at = restart;
    full_at    = (full_off >= 0) ? (beat_glob + full_off) : -1;
    start_req  = 1'b1;
    tick();
    tick();
    check_eq("busy_run", 64'(busy), 64'd1);
    wait_done(4000);
    d0 = ndone;
    repeat (10) tick();
    check_eq("done_once", 64'(ndone - d0), 64'd0);
    check_eq("write_count", 64'(nwr - w0),
             64'(H_WORDS * V_LINES + ((restart >= 0) ? restart : 0)));
  endtask

  initial begin
    int rc;
    int w0;
    int rs;
    rst_n = 1'b0;
    frame_start = 1'b0;
    fifo_full = 1'b0;
    rd_req_ack = 1'b0;
    rd_data_valid = 1'b0;
    rd_data = '0;
    fifo_wr_water_level = '0;

    // reset with random inputs
    rand_in = 1'b1;
    repeat (3) tick();
    rand_in = 1'b0;
    tick();
    check_eq("rst_rd_req", 64'(rd_req), 64'd0);
    check_eq("rst_wr_en", 64'(fifo_wr_en), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(frame_done), 64'd0);
    check_eq("rst_ovf", 64'(overflow_err), 64'd0);
    check_eq("rst_len", 64'(rd_len), 64'd0);
    rst_n = 1'b1;
    rc = req_cycles;
    repeat (10) tick();
    check_eq("idle_no_req", 64'(req_cycles - rc), 64'd0);
    check_eq("idle_busy", 64'(busy), 64'd0);

    // line split over a whole frame, strays present
    stray_en = 1'b1;
    run_frame(-1, -1);
    check_eq("ovf_clean", 64'(overflow_err), 64'd0);

    // space gating around the burst+margin threshold
    stray_en = 1'b0;
    level = 11'd1000;
    w0 = nwr;
    start_req = 1'b1;
    rc = req_cycles;
    repeat (20) tick();
    check_eq("gate_1000", 64'(req_cycles - rc), 64'd0);
    start_req = 1'b1;
    repeat (5) tick();
    level = 11'd959;
    repeat (20) tick();
    check_eq("gate_959", 64'(req_cycles - rc), 64'd0);
    check_eq("gate_busy", 64'(busy), 64'd1);
    level = 11'd958;
    tick();
    tick();
    check_eq("gate_958", 64'(req_cycles > rc), 64'd1);
    wait_done(4000);
    check_eq("gate_writes", 64'(nwr - w0), 64'(H_WORDS * V_LINES));

    // delayed acknowledge holds each request
    level = '0;
    stray_en = 1'b1;
    ack_delay = 5;
    rc = req_cycles;
    run_frame(-1, -1);
    check_eq("req_hold_cycles", 64'(req_cycles - rc), 64'(frame_bursts * 6));
    ack_delay = 0;

    // restart after 10 beats of the first burst
    run_frame(10, -1);

    // one beat while FIFO full
    run_frame(-1, 37);
    check_eq("ovf_set", 64'(overflow_err), 64'd1);
    start_req = 1'b1;
    tick();
    tick();
    check_eq("ovf_clear", 64'(overflow_err), 64'd0);
    wait_done(4000);

    // randomized frames
    rand_ack = 1'b1;
    for (int f = 0; f < 4; f++) begin
      level = (ADDR_WIDTH+1)'($urandom_range(0, 900));
      rs = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 40)) : -1;
      run_frame(rs, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
